// File: rtl/ex_div_seq_pkg.sv
// Shared divide-op encodings for the Execute-stage divide sequencer.
package ex_div_seq_pkg;

    localparam int unsigned DIV_OP_WIDTH = 2;

    localparam logic [DIV_OP_WIDTH-1:0] DIV_DIV  = 2'd0;  // signed quotient
    localparam logic [DIV_OP_WIDTH-1:0] DIV_DIVU = 2'd1;  // unsigned quotient
    localparam logic [DIV_OP_WIDTH-1:0] DIV_MOD  = 2'd2;  // signed remainder
    localparam logic [DIV_OP_WIDTH-1:0] DIV_MODU = 2'd3;  // unsigned remainder

endpackage

// File: rtl/ex_div_seq_div_iter_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor, keep if non-negative.
module div_iter_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);

    // The shifted remainder can exceed DATA_WIDTH bits, so the trial runs one bit wider.
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] trial;

    // Trial subtract and restore on borrow
    always_comb begin
        shifted = {rem, quo[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[DATA_WIDTH]) begin
            rem_next = shifted[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle signed/unsigned DIV/MOD sequencer that stalls Execute until the result is ready.
module ex_div_seq
    import ex_div_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DIV_OP_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]   oprand1,
    input  logic [DATA_WIDTH-1:0]   oprand2,
    input  logic                    flush,
    output logic                    busy,
    output logic                    stall_req,
    output logic                    valid_out,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    state_e                  state_q, state_d;
    logic [DIV_OP_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q, div_q, rem_q, quo_q, result_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    q_neg_q, r_neg_q;

    logic                    is_signed, is_mod;
    logic [DATA_WIDTH-1:0]   abs_a, abs_b, rem_nxt, quo_nxt, q_fix, r_fix;

    assign is_signed = (op_q == DIV_DIV) || (op_q == DIV_MOD);
    assign is_mod    = (op_q == DIV_MOD) || (op_q == DIV_MODU);

    // |MIN| = 2^(W-1) still fits in an unsigned W-bit magnitude.
    assign abs_a = (is_signed && a_q[MSB]) ? ('0 - a_q) : a_q;
    assign abs_b = (is_signed && b_q[MSB]) ? ('0 - b_q) : b_q;
    assign q_fix = q_neg_q ? ('0 - quo_q) : quo_q;
    assign r_fix = r_neg_q ? ('0 - rem_q) : rem_q;

    div_iter_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall request; flush overrides everything combinationally
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StPrep;
                    stall_req = 1'b1;
                end
            end
            StPrep: begin
                stall_req = 1'b1;
                state_d   = (b_q == '0) ? StDone : StCalc;
            end
            StCalc: begin
                stall_req = 1'b1;
                if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                stall_req = 1'b1;
                state_d   = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d   = StIdle;
            stall_req = 1'b0;
        end
    end

    // Datapath: operand capture, magnitude prep, iteration and sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else if (!flush) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= oprand1;
                        b_q  <= oprand2;
                    end
                end
                StPrep: begin
                    div_q   <= abs_b;
                    quo_q   <= abs_a;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    q_neg_q <= is_signed && (a_q[MSB] ^ b_q[MSB]);
                    r_neg_q <= is_signed && a_q[MSB];
                    // Divide by zero: quotient all ones, remainder is the raw dividend.
                    if (b_q == '0) begin
                        result_q <= is_mod ? a_q : '1;
                    end
                end
                StCalc: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
                StFix:   result_q <= is_mod ? r_fix : q_fix;
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign valid_out = (state_q == StDone);
    assign result    = result_q;

endmodule
